// File: rtl/instruction_fetch_unit.sv
// Multi-cycle instruction fetch and next-PC sequencer.
// Fetches over req/ack and issues to decode over valid/ready.
`timescale 1ns/1ps
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc4,
  input  logic        PCSrc,
  input  logic        BranchTaken,
  input  logic [31:0] BranchOffset,
  input  logic        j_Control,
  input  logic        jal_Control,
  output logic [31:0] link_addr,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign imem_addr = pc;

  assign br_target = instr_pc4 + {BranchOffset[29:0], 2'b00};
  assign j_target  = {instr_pc4[31:28], instr[25:0], 2'b00};

  // jump outranks a simultaneously taken branch
  always_comb begin
    next_pc = instr_pc4;
    if (j_Control)
      next_pc = j_target;
    else if (PCSrc && BranchTaken)
      next_pc = br_target;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc4   <= 32'h0;
      link_addr   <= 32'h0;
      instr_count <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc4   <= pc + 32'd4;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            instr_count <= instr_count + 32'd1;
            if (jal_Control)
              link_addr <= instr_pc4;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table of fetch
// transactions plus hand-written reset sequences.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc4;
  logic        PCSrc = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchOffset = 32'h0;
  logic        j_Control = 1'b0;
  logic        jal_Control = 1'b0;
  logic [31:0] link_addr;
  logic [31:0] instr_count;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
    .Clk(Clk), .Rst(Rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc4(instr_pc4),
    .PCSrc(PCSrc), .BranchTaken(BranchTaken),
    .BranchOffset(BranchOffset),
    .j_Control(j_Control), .jal_Control(jal_Control),
    .link_addr(link_addr), .instr_count(instr_count)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          aw;
    int          rw;
    logic        pcsrc;
    logic        bt;
    logic [31:0] off;
    logic        j;
    logic        jal;
    logic [31:0] link;
  } vec_t;

  vec_t vecs [12];
  int   tests = 0;
  int   fails = 0;
  int   start_cyc = 0;
  int   prev_wait = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    if (i > 0)
      chk("spacing", 32'(cyc - start_cyc), 32'(2 + prev_wait));
    start_cyc = cyc;
    prev_wait = v.aw + v.rw;
    chk("req", {31'h0, imem_req}, 32'h1);
    chk("valid_low", {31'h0, instr_valid}, 32'h0);
    chk("fetch_addr", imem_addr, v.addr);
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    repeat (v.aw) begin
      @(posedge Clk); #1;
      chk("addr_stable", imem_addr, v.addr);
      chk("req_held", {31'h0, imem_req}, 32'h1);
    end
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    @(posedge Clk); #1;
    chk("valid_rise", {31'h0, instr_valid}, 32'h1);
    chk("req_fall", {31'h0, imem_req}, 32'h0);
    chk("instr", instr, v.rdata);
    chk("instr_pc4", instr_pc4, v.addr + 32'd4);
    instr_ready = 1'b0;
    imem_rdata  = ~v.rdata;
    repeat (v.rw) begin
      @(posedge Clk); #1;
      chk("valid_held", {31'h0, instr_valid}, 32'h1);
      chk("instr_held", instr, v.rdata);
      chk("req_off", {31'h0, imem_req}, 32'h0);
    end
    imem_ack     = 1'b0;
    instr_ready  = 1'b1;
    PCSrc        = v.pcsrc;
    BranchTaken  = v.bt;
    BranchOffset = v.off;
    j_Control    = v.j;
    jal_Control  = v.jal;
    @(posedge Clk); #1;
    instr_ready  = 1'b0;
    PCSrc        = 1'b0;
    BranchTaken  = 1'b0;
    BranchOffset = 32'h0;
    j_Control    = 1'b0;
    jal_Control  = 1'b0;
    chk("count", instr_count, 32'(i + 1));
    chk("link", link_addr, v.link);
    chk("valid_fall", {31'h0, instr_valid}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0040, 32'h2108_0001, 0, 0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000_0044, 32'h3C01_1234, 0, 0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0048};
    vecs[2]  = '{32'h0000_0048, 32'h8C22_0004, 3, 2,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0048};
    vecs[3]  = '{32'h0000_004C, 32'h0800_0040, 0, 0,
                 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0048};
    vecs[4]  = '{32'h0000_0100, 32'h1000_FFFE, 0, 0,
                 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0000_0048};
    vecs[5]  = '{32'h0000_00FC, 32'h0000_0020, 0, 0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0048};
    vecs[6]  = '{32'h0000_0100, 32'h1400_FFFE, 0, 0,
                 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0000_0048};
    vecs[7]  = '{32'h0000_0104, 32'h1000_FFC2, 0, 0,
                 1'b1, 1'b1, 32'h03FF_FFC2, 1'b0, 1'b0, 32'h0000_0048};
    vecs[8]  = '{32'h1000_0010, 32'h0C00_0400, 0, 0,
                 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_0014};
    vecs[9]  = '{32'h1000_1000, 32'h0800_0010, 0, 0,
                 1'b1, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 32'h1000_0014};
    vecs[10] = '{32'h1000_0040, 32'h1000_FFEE, 0, 0,
                 1'b1, 1'b1, 32'h3BFF_FFEE, 1'b0, 1'b0, 32'h1000_0014};
    vecs[11] = '{32'hFFFF_FFFC, 32'h0000_0000, 1, 1,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1000_0014};

    // reset values
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0000_0040);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc4", instr_pc4, 32'h0);
    chk("rst_link", link_addr, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    Rst = 1'b0;
    #3;
    chk("req_before_edge", {31'h0, imem_req}, 32'h0);
    @(posedge Clk); #1;

    for (int i = 0; i < 12; i++)
      run_vec(i);

    // wrapped fetch at 0, then async reset mid-FETCH
    chk("spacing_wrap", 32'(cyc - start_cyc), 32'(2 + prev_wait));
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_req", {31'h0, imem_req}, 32'h1);
    @(posedge Clk); #2;
    Rst = 1'b1;
    #1;
    chk("async_req", {31'h0, imem_req}, 32'h0);
    chk("async_pc", imem_addr, 32'h0000_0040);
    chk("async_count", instr_count, 32'h0);
    chk("async_link", link_addr, 32'h0);
    @(posedge Clk); #1;
    Rst      = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge Clk); #1;
    imem_ack = 1'b0;
    chk("idle_ack_ignored", {31'h0, instr_valid}, 32'h0);
    chk("refetch_req", {31'h0, imem_req}, 32'h1);
    chk("refetch_addr", imem_addr, 32'h0000_0040);
    chk("refetch_instr", instr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
